aes_encrypt_arbiter: RTL and testbench

- Shares one instance of the combinational AES-128 encrypt core (fixed key, 128-bit in/out, `start`/`done_encr` gating) between two requesters.
- Each requester uses a valid/ready handshake. Grants are round-robin.
- The core's deep combinational path is treated as a multicycle path: operands are held stable for SETTLE_CYCLES, then the ciphertext is registered and returned with the requester ID.
- Sits between the system request fabric and the encrypt core.

---
 rtl/aes_encrypt_arbiter.sv | 114 +++++++++++
 tb/tb_aes_encrypt_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_arbiter.sv
// rtl/aes_encrypt_arbiter.sv - round-robin arbiter sharing one combinational AES-128 encrypt core
//
// Two requesters hand plaintext blocks over valid/ready; one block at a time is
// driven into the core, held for SETTLE_CYCLES (multicycle path), then the
// ciphertext is registered and returned with the owning requester's id.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/ready/data    requester 0 plaintext handshake (128-bit)
//   req1_valid/ready/data    requester 1 plaintext handshake (128-bit)
//   core_start, core_in      registered operand and start to the encrypt core
//   core_out, core_done      ciphertext and done from the encrypt core
//   rsp_valid/ready/data/id  ciphertext response with requester id
//   busy                     high whenever a block is in flight
//   op_count                 completed responses, wraps at 2^CNT_W

module aes_encrypt_arbiter #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [127:0]     req0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [127:0]     req1_data,
   output logic             core_start,
   output logic [127:0]     core_in,
   input  logic [127:0]     core_out,
   input  logic             core_done,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [127:0]     rsp_data,
   output logic             rsp_id,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Terminal settle count; an 8-bit counter covers SETTLE_CYCLES up to 255.
   localparam logic [7:0] TERM_CNT = 8'(SETTLE_CYCLES - 1);

   logic [1:0] state;
   logic       last_grant;
   logic [7:0] cnt;
   logic       idle;
   logic       gnt0;
   logic       gnt1;

   assign idle = (state == ST_IDLE);

   // Requester 0 wins when alone or when requester 1 was served last;
   // a lone requester is therefore served back-to-back.
   assign gnt0 = idle & req0_valid & (~req1_valid | last_grant);
   assign gnt1 = idle & req1_valid & ~gnt0;

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign core_start = (state == ST_SETTLE);
   assign busy       = ~idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         cnt        <= 8'd0;
         core_in    <= 128'd0;
         rsp_data   <= 128'd0;
         rsp_id     <= 1'b0;
         rsp_valid  <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt0 | gnt1) begin
                  core_in    <= gnt1 ? req1_data : req0_data;
                  rsp_id     <= gnt1;
                  last_grant <= gnt1;
                  cnt        <= 8'd0;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // Count out the settle window first; only then is core_done
               // consulted, stalling at the terminal count until it is high.
               if (cnt < TERM_CNT) begin
                  cnt <= cnt + 8'd1;
               end else if (core_done) begin
                  rsp_data  <= core_out;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encrypt_arbiter.sv
// tb/tb_aes_encrypt_arbiter.sv - self-checking bench for aes_encrypt_arbiter with a behavioural AES-128 core

module tb_aes_encrypt_arbiter;

   localparam int SETTLE = 4;
   localparam int CW     = 2;
   localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [127:0]  req0_data, req1_data;
   logic          core_start, core_done;
   logic [127:0]  core_in, core_out;
   logic          rsp_valid, rsp_ready, rsp_id, busy;
   logic [127:0]  rsp_data;
   logic [CW-1:0] op_count;

   int tests_run = 0;
   int fails     = 0;
   int cycle     = 0;
   int exp_cnt   = 0;
   int model_last = 1;

   aes_encrypt_arbiter #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .core_start(core_start), .core_in(core_in), .core_out(core_out), .core_done(core_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // ---------------- behavioural AES-128 (FIPS-197) ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] b = x;
      logic [7:0] e = 8'hfe;
      for (int k = 0; k < 8; k++) begin
         if (e[k]) r = gmul(r, b);
         b = gmul(b, b);
      end
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt);
      logic [31:0]  w [0:43];
      logic [7:0]   s [0:15];
      logic [7:0]   t [0:15];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] key;
      logic [127:0] ct;
      logic [7:0]   a0, a1, a2, a3;
      key = AES_KEY;
      rc  = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
         for (int i = 0; i < 16; i++) s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      return ct;
   endfunction

   assign core_out = aes_enc(core_in);

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic apply_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = '0; req1_data = '0;
      core_done = 1'b1; rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      model_last = 1;
   endtask

   // Returns just after a negedge with a ready high; the next posedge is the accept.
   task automatic wait_grant(output int who, output bit to);
      who = -1; to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (req0_ready) begin who = 0; to = 1'b0; return; end
         if (req1_ready) begin who = 1; to = 1'b0; return; end
         @(negedge clk);
      end
   endtask

   // Called at the negedge right after the accept edge; counts edges until rsp_valid.
   task automatic wait_rsp(input int stall, output int edges, output bit to, output bit rdy_seen);
      edges = 0; rdy_seen = 1'b0;
      if (stall > 0) core_done = 1'b0;
      while (!rsp_valid && edges < 60) begin
         if (req0_ready || req1_ready) rdy_seen = 1'b1;
         if (stall > 0 && edges == SETTLE - 1 + stall) core_done = 1'b1;
         @(negedge clk);
         edges++;
      end
      if (req0_ready || req1_ready) rdy_seen = 1'b1;
      core_done = 1'b1;
      to = !rsp_valid;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
      core_done = 1'b1; rsp_ready = 1'b0;
      @(negedge clk); #1;
      tests_run++; if ({busy, core_start, rsp_valid, rsp_id, req0_ready, req1_ready} !== 6'b0) begin fails++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, core_start, rsp_valid, rsp_id, req0_ready, req1_ready}); end
      tests_run++; if (core_in !== 128'd0) begin fails++; $display("FAIL reset_core_in: got %h expected 0", core_in); end
      tests_run++; if (rsp_data !== 128'd0) begin fails++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
      tests_run++; if (op_count !== '0) begin fails++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
      rst = 1'b0; exp_cnt = 0; model_last = 1;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++; if (rsp_valid !== 1'b0 || op_count !== '0 || busy !== 1'b0) begin fails++; $display("FAIL idle_rsp_ready: got valid=%b cnt=%0d busy=%b expected 0/0/0", rsp_valid, op_count, busy); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_single();
      int who, edges; bit to, rdy;
      apply_reset();
      rsp_ready = 1'b1;
      req0_data = VEC_PT; req0_valid = 1'b1;
      wait_grant(who, to);
      tests_run++; if (to || who != 0) begin fails++; $display("FAIL single_grant: got %0d expected 0", who); end
      @(negedge clk);
      req0_valid = 1'b0; req0_data = rand128();
      tests_run++; if (core_start !== 1'b1 || busy !== 1'b1 || core_in !== VEC_PT) begin fails++; $display("FAIL single_settle: got start=%b busy=%b in=%h expected 1/1/%h", core_start, busy, core_in, VEC_PT); end
      wait_rsp(0, edges, to, rdy);
      tests_run++; if (to || edges != SETTLE) begin fails++; $display("FAIL single_latency: got %0d expected %0d", edges, SETTLE); end
      tests_run++; if (rsp_data !== VEC_CT) begin fails++; $display("FAIL single_data: got %h expected %h", rsp_data, VEC_CT); end
      tests_run++; if (rsp_id !== 1'b0 || core_start !== 1'b0) begin fails++; $display("FAIL single_id: got id=%b start=%b expected 0/0", rsp_id, core_start); end
      @(negedge clk);
      exp_cnt++;
      tests_run++; if (op_count !== CW'(exp_cnt) || rsp_valid !== 1'b0) begin fails++; $display("FAIL single_count: got %0d valid=%b expected %0d/0", op_count, rsp_valid, CW'(exp_cnt)); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_both();
      int who, edges, c0, c1; bit to, rdy;
      apply_reset();
      rsp_ready = 1'b1;
      req0_data = VEC_PT; req1_data = 128'd0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_grant(who, to);
      tests_run++; if (to || who != 0) begin fails++; $display("FAIL both_first: got %0d expected 0", who); end
      c0 = cycle;
      @(negedge clk);
      req0_valid = 1'b0;
      wait_rsp(0, edges, to, rdy);
      tests_run++; if (to || rdy) begin fails++; $display("FAIL both_ready_busy: got ready_seen=%b timeout=%b expected 0/0", rdy, to); end
      tests_run++; if (rsp_data !== VEC_CT || rsp_id !== 1'b0) begin fails++; $display("FAIL both_rsp0: got %h id %b expected %h id 0", rsp_data, rsp_id, VEC_CT); end
      @(negedge clk);
      exp_cnt++;
      wait_grant(who, to);
      c1 = cycle;
      tests_run++; if (to || who != 1) begin fails++; $display("FAIL both_second: got %0d expected 1", who); end
      tests_run++; if (c1 - c0 != SETTLE + 2) begin fails++; $display("FAIL both_interval: got %0d expected %0d", c1 - c0, SETTLE + 2); end
      @(negedge clk);
      req1_valid = 1'b0;
      wait_rsp(0, edges, to, rdy);
      tests_run++; if (to || rsp_data !== aes_enc(128'd0) || rsp_id !== 1'b1) begin fails++; $display("FAIL both_rsp1: got %h id %b expected %h id 1", rsp_data, rsp_id, aes_enc(128'd0)); end
      @(negedge clk);
      exp_cnt++;
      tests_run++; if (op_count !== CW'(exp_cnt)) begin fails++; $display("FAIL both_count: got %0d expected %0d", op_count, CW'(exp_cnt)); end
      rsp_ready = 1'b0;
      model_last = 1;
   endtask

   task automatic test_backpressure();
      int who, edges; bit to, rdy, unstable, rdy_bad, cnt_bad;
      logic [127:0] d, exp_ct;
      d = rand128(); exp_ct = aes_enc(d);
      rsp_ready = 1'b0;
      req1_data = d; req1_valid = 1'b1;
      wait_grant(who, to);
      tests_run++; if (to || who != 1) begin fails++; $display("FAIL bp_grant: got %0d expected 1", who); end
      @(negedge clk);
      req1_valid = 1'b0; req1_data = rand128();
      wait_rsp(0, edges, to, rdy);
      req0_valid = 1'b1; req1_valid = 1'b1;
      unstable = to; rdy_bad = 1'b0; cnt_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_ct || rsp_id !== 1'b1) unstable = 1'b1;
         if (req0_ready || req1_ready) rdy_bad = 1'b1;
         if (op_count !== CW'(exp_cnt)) cnt_bad = 1'b1;
      end
      tests_run++; if (unstable) begin fails++; $display("FAIL bp_hold: got valid=%b data=%h id=%b expected 1/%h/1", rsp_valid, rsp_data, rsp_id, exp_ct); end
      tests_run++; if (rdy_bad || cnt_bad) begin fails++; $display("FAIL bp_ready_count: got ready_seen=%b count_moved=%b expected 0/0", rdy_bad, cnt_bad); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_cnt++;
      model_last = 1;
      tests_run++; if (op_count !== CW'(exp_cnt) || rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got %0d valid=%b expected %0d/0", op_count, rsp_valid, CW'(exp_cnt)); end
   endtask

   task automatic test_stall();
      int who, edges; bit to, rdy;
      logic [127:0] d;
      d = rand128();
      rsp_ready = 1'b1;
      req0_data = d; req0_valid = 1'b1;
      wait_grant(who, to);
      @(negedge clk);
      req0_valid = 1'b0;
      wait_rsp(3, edges, to, rdy);
      tests_run++; if (to || edges != SETTLE + 3) begin fails++; $display("FAIL stall_latency: got %0d expected %0d", edges, SETTLE + 3); end
      tests_run++; if (rsp_data !== aes_enc(d) || rsp_id !== 1'b0) begin fails++; $display("FAIL stall_data: got %h expected %h", rsp_data, aes_enc(d)); end
      @(negedge clk);
      exp_cnt++;
      model_last = 0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      int who, edges; bit to, rdy, ghost;
      logic [127:0] d;
      d = rand128();
      req0_data = d; req0_valid = 1'b1;
      wait_grant(who, to);
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests_run++; if ({busy, core_start, rsp_valid, rsp_id} !== 4'b0 || core_in !== 128'd0 || op_count !== '0) begin fails++; $display("FAIL async_reset: got busy=%b start=%b in=%h cnt=%0d expected all 0", busy, core_start, core_in, op_count); end
      @(negedge clk);
      rst = 1'b0; exp_cnt = 0; model_last = 1;
      rsp_ready = 1'b1;
      ghost = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) ghost = 1'b1;
      end
      tests_run++; if (ghost) begin fails++; $display("FAIL async_ghost: got a response after reset expected none"); end
      d = rand128();
      req0_data = d; req1_data = rand128();
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_grant(who, to);
      tests_run++; if (to || who != 0) begin fails++; $display("FAIL async_priority: got %0d expected 0", who); end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(0, edges, to, rdy);
      tests_run++; if (to || rsp_data !== aes_enc(d) || edges != SETTLE) begin fails++; $display("FAIL async_after: got %h lat %0d expected %h lat %0d", rsp_data, edges, aes_enc(d), SETTLE); end
      @(negedge clk);
      exp_cnt++;
      model_last = 0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      bit v0 = 1'b0, v1 = 1'b0, to, rdy;
      logic [127:0] d0, d1, exp_ct;
      int who, exp_who, edges, stall, bp;
      for (int t = 0; t < 16; t++) begin
         if (!v0) begin v0 = 1'($urandom_range(0, 1)); d0 = rand128(); end
         if (!v1) begin v1 = 1'($urandom_range(0, 1)); d1 = rand128(); end
         if (!v0 && !v1) v0 = 1'b1;
         exp_who = (v0 && v1) ? (model_last == 0 ? 1 : 0) : (v0 ? 0 : 1);
         req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
         wait_grant(who, to);
         tests_run++; if (to || who != exp_who) begin fails++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", t, who, exp_who); end
         exp_ct = aes_enc(exp_who == 1 ? d1 : d0);
         model_last = exp_who;
         @(negedge clk);
         if (exp_who == 0) begin v0 = 1'b0; req0_valid = 1'b0; req0_data = rand128(); end
         else begin v1 = 1'b0; req1_valid = 1'b0; req1_data = rand128(); end
         stall = $urandom_range(0, 2);
         rsp_ready = 1'b0;
         wait_rsp(stall, edges, to, rdy);
         tests_run++; if (to || rdy || edges != SETTLE + stall) begin fails++; $display("FAIL rand_latency[%0d]: got %0d ready_seen=%b expected %0d", t, edges, rdy, SETTLE + stall); end
         tests_run++; if (rsp_data !== exp_ct || rsp_id !== 1'(exp_who)) begin fails++; $display("FAIL rand_data[%0d]: got %h id %b expected %h id %0d", t, rsp_data, rsp_id, exp_ct, exp_who); end
         bp = $urandom_range(0, 3);
         repeat (bp) @(negedge clk);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         exp_cnt++;
         tests_run++; if (op_count !== CW'(exp_cnt)) begin fails++; $display("FAIL rand_count[%0d]: got %0d expected %0d", t, op_count, CW'(exp_cnt)); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      int who, edges; bit to, rdy;
      int seq [5] = '{1, 2, 3, 0, 1};
      apply_reset();
      rsp_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         req1_data = rand128(); req1_valid = 1'b1;
         wait_grant(who, to);
         @(negedge clk);
         req1_valid = 1'b0;
         wait_rsp(0, edges, to, rdy);
         @(negedge clk);
         tests_run++; if (to || op_count !== CW'(seq[n])) begin fails++; $display("FAIL wrap[%0d]: got %0d expected %0d", n, op_count, seq[n]); end
      end
      rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_both();
      test_backpressure();
      test_stall();
      test_async_reset();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
